moore_seq_detector: RTL and testbench



---
 rtl/moore_seq_detector.sv | 106 ++++++++++
 tb/tb_moore_seq_detector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector.sv
// Moore sequence detector for a stream of SYM_W-bit symbols.
// Matches a runtime-loadable pattern of SEQ_LEN symbols, in overlapping or
// non-overlapping mode, and keeps a saturating count of completed matches.
//
// Ports:
//   CLK          rising-edge clock
//   Reset        synchronous active-high reset (restores PATTERN_INIT)
//   Input        current symbol
//   In_Valid     Input is accepted on this edge when high
//   Overlap      1 = overlapping detection, 0 = restart after a full match
//   Load         load Pattern_In into the pattern register and restart
//   Pattern_In   new pattern, symbol i at bits [i*SYM_W +: SYM_W]
//   isTrue       high while the state equals SEQ_LEN (full match)
//   Match_Count  number of completed matches, saturating
module moore_seq_detector #(
  parameter int unsigned                     SYM_W        = 4,
  parameter int unsigned                     SEQ_LEN      = 4,
  parameter logic [SEQ_LEN*SYM_W-1:0]        PATTERN_INIT = 16'h2121,
  parameter int unsigned                     COUNT_W      = 8
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [SYM_W-1:0]         Input,
  input  logic                     In_Valid,
  input  logic                     Overlap,
  input  logic                     Load,
  input  logic [SEQ_LEN*SYM_W-1:0] Pattern_In,
  output logic                     isTrue,
  output logic [COUNT_W-1:0]       Match_Count
);

  localparam int unsigned ST_W = $clog2(SEQ_LEN + 1);
  localparam int unsigned HC_W = $clog2(SEQ_LEN);

  localparam logic [ST_W-1:0]    ST_FULL   = ST_W'(SEQ_LEN);
  localparam logic [HC_W-1:0]    HCNT_MAX  = HC_W'(SEQ_LEN - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [SEQ_LEN*SYM_W-1:0] r_pat;
  logic [ST_W-1:0]          r_state;
  logic [HC_W-1:0]          r_hcnt;
  // r_hist[0] is the most recently accepted symbol.
  logic [SYM_W-1:0]         r_hist [SEQ_LEN-1];
  logic [COUNT_W-1:0]       r_count;

  logic [HC_W-1:0]          w_h_eff;
  logic [HC_W-1:0]          w_h_next;
  logic [ST_W-1:0]          w_next_state;
  logic                     w_ok;

  // Longest suffix of (valid history, Input) that equals a prefix of the pattern.
  always_comb begin
    w_h_eff      = r_hcnt;
    w_next_state = '0;
    w_ok         = 1'b0;
    // Non-overlapping: a finished match leaves nothing usable for the next one.
    if (!Overlap && (r_state == ST_FULL)) begin
      w_h_eff = '0;
    end
    for (int k = 1; k <= int'(SEQ_LEN); k++) begin
      w_ok = (k <= int'(w_h_eff) + 1) && (Input == r_pat[(k-1)*SYM_W +: SYM_W]);
      for (int j = 0; j <= k - 2; j++) begin
        if (r_hist[j] != r_pat[(k-2-j)*SYM_W +: SYM_W]) begin
          w_ok = 1'b0;
        end
      end
      if (w_ok) begin
        w_next_state = ST_W'(k);
      end
    end
    w_h_next = (w_h_eff < HCNT_MAX) ? (w_h_eff + HC_W'(1)) : w_h_eff;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_pat   <= PATTERN_INIT;
      r_state <= '0;
      r_hcnt  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(SEQ_LEN) - 1; i++) begin
        r_hist[i] <= '0;
      end
    end else if (Load) begin
      r_pat   <= Pattern_In;
      r_state <= '0;
      r_hcnt  <= '0;
      for (int i = 0; i < int'(SEQ_LEN) - 1; i++) begin
        r_hist[i] <= '0;
      end
    end else if (In_Valid) begin
      r_state   <= w_next_state;
      r_hcnt    <= w_h_next;
      r_hist[0] <= Input;
      for (int i = 1; i < int'(SEQ_LEN) - 1; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
      if ((w_next_state == ST_FULL) && (r_count != COUNT_MAX)) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign isTrue      = (r_state == ST_FULL);
  assign Match_Count = r_count;

endmodule

// File: tb/tb_moore_seq_detector.sv
module tb_moore_seq_detector;

  localparam int unsigned SYM_W   = 4;
  localparam int unsigned SEQ_LEN = 4;
  localparam logic [15:0] PINIT   = 16'h2121;

  logic        CLK;
  logic        Reset;
  logic [3:0]  Input;
  logic        In_Valid;
  logic        Overlap;
  logic        Load;
  logic [15:0] Pattern_In;
  logic        is_true8, is_true2;
  logic [7:0]  count8;
  logic [1:0]  count2;

  moore_seq_detector #(
    .SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN), .PATTERN_INIT(PINIT), .COUNT_W(8)
  ) dut8 (
    .CLK(CLK), .Reset(Reset), .Input(Input), .In_Valid(In_Valid), .Overlap(Overlap),
    .Load(Load), .Pattern_In(Pattern_In), .isTrue(is_true8), .Match_Count(count8)
  );

  moore_seq_detector #(
    .SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN), .PATTERN_INIT(PINIT), .COUNT_W(2)
  ) dut2 (
    .CLK(CLK), .Reset(Reset), .Input(Input), .In_Valid(In_Valid), .Overlap(Overlap),
    .Load(Load), .Pattern_In(Pattern_In), .isTrue(is_true2), .Match_Count(count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: raw accepted-symbol queue and unbounded match tally.
  logic [3:0] m_pat [SEQ_LEN];
  logic [3:0] m_hist [$];
  int         m_state = 0;
  int         m_raw   = 0;
  bit         m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_pat(input logic [15:0] p);
    for (int i = 0; i < int'(SEQ_LEN); i++) m_pat[i] = p[i*SYM_W +: SYM_W];
  endtask

  task automatic model_edge();
    int  best;
    int  n;
    bit  ok;
    if (Reset) begin
      set_pat(PINIT);
      m_state = 0;
      m_hist.delete();
      m_raw   = 0;
      m_valid = 1'b1;
    end else if (Load) begin
      set_pat(Pattern_In);
      m_state = 0;
      m_hist.delete();
    end else if (In_Valid) begin
      if (!Overlap && m_state == int'(SEQ_LEN)) m_hist.delete();
      m_hist.push_back(Input);
      if (m_hist.size() > int'(SEQ_LEN)) void'(m_hist.pop_front());
      n    = m_hist.size();
      best = 0;
      for (int k = 1; k <= n; k++) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) if (m_hist[n-k+i] != m_pat[i]) ok = 1'b0;
        if (ok) best = k;
      end
      m_state = best;
      if (best == int'(SEQ_LEN)) m_raw++;
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (m_valid) begin
        chk("cyc_isTrue8", is_true8, m_state == int'(SEQ_LEN));
        chk("cyc_isTrue2", is_true2, m_state == int'(SEQ_LEN));
        chk("cyc_count8", count8, sat(m_raw, 255));
        chk("cyc_count2", count2, sat(m_raw, 3));
      end
    end
  end

  task automatic tick(input logic v, input logic [3:0] x, input logic ov);
    In_Valid = v;
    Input    = x;
    Overlap  = ov;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // Accept one symbol and pin the model state to a hand-derived value.
  task automatic sym(input logic [3:0] x, input logic ov, input int exp_s);
    tick(1'b1, x, ov);
    chk("model_S", m_state, exp_s);
    chk("isTrue", is_true8, exp_s == int'(SEQ_LEN));
  endtask

  task automatic idle(input int exp_s);
    tick(1'b0, 4'hF, 1'b1);
    chk("idle_S", m_state, exp_s);
    chk("idle_isTrue", is_true8, exp_s == int'(SEQ_LEN));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(1'b0, 4'h0, 1'b1);
    Reset = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    Load       = 1'b0;
    In_Valid   = 1'b0;
    Input      = 4'h0;
    Overlap    = 1'b1;
    Pattern_In = 16'h0;

    do_reset();
    tick(1'b0, 4'h0, 1'b1);
    chk("reset_isTrue", is_true8, 1'b0);
    chk("reset_count", count8, 8'd0);

    // Overlapping detection on the default pattern 1,2,1,2.
    sym(4'd1, 1, 1); sym(4'd2, 1, 2); sym(4'd1, 1, 3);
    sym(4'd2, 1, 4); sym(4'd1, 1, 3); sym(4'd2, 1, 4);
    chk("ovl_count", count8, 8'd2);

    // Non-overlapping on the same stream.
    do_reset();
    sym(4'd1, 0, 1); sym(4'd2, 0, 2); sym(4'd1, 0, 3);
    sym(4'd2, 0, 4); sym(4'd1, 0, 1); sym(4'd2, 0, 2);
    chk("novl_count", count8, 8'd1);

    // Fallback after a broken partial match.
    do_reset();
    sym(4'd1, 1, 1); sym(4'd2, 1, 2); sym(4'd1, 1, 3); sym(4'd1, 1, 1);
    sym(4'd2, 1, 2); sym(4'd1, 1, 3); sym(4'd2, 1, 4);
    chk("fallback_count", count8, 8'd1);

    // Gaps in In_Valid hold the state; isTrue holds through idle.
    do_reset();
    sym(4'd1, 1, 1); repeat (3) idle(1);
    sym(4'd2, 1, 2); repeat (3) idle(2);
    sym(4'd1, 1, 3); repeat (3) idle(3);
    sym(4'd2, 1, 4); repeat (5) idle(4);
    chk("gap_count", count8, 8'd1);

    // Load mid-sequence at S=3; Input on the Load edge is ignored.
    sym(4'd1, 1, 3);
    Load       = 1'b1;
    Pattern_In = 16'h9999;
    tick(1'b1, 4'd9, 1'b1);
    Load       = 1'b0;
    chk("load_S", m_state, 0);
    chk("load_isTrue", is_true8, 1'b0);
    chk("load_count", count8, 8'd1);
    sym(4'd9, 1, 1); sym(4'd9, 1, 2); sym(4'd9, 1, 3); sym(4'd9, 1, 4); sym(4'd9, 1, 4);
    chk("load_count_after", count8, 8'd3);

    // Reset while matched with count 5; Reset outranks a simultaneous Load.
    sym(4'd9, 1, 4); sym(4'd9, 1, 4);
    chk("pre_reset_count8", count8, 8'd5);
    chk("pre_reset_count2", count2, 2'd3);
    Reset      = 1'b1;
    Load       = 1'b1;
    Pattern_In = 16'h9999;
    tick(1'b1, 4'd9, 1'b1);
    Reset      = 1'b0;
    Load       = 1'b0;
    chk("rst_isTrue", is_true8, 1'b0);
    chk("rst_count8", count8, 8'd0);
    chk("rst_count2", count2, 2'd0);
    sym(4'd9, 1, 0);
    sym(4'd1, 1, 1); sym(4'd2, 1, 2); sym(4'd1, 1, 3); sym(4'd2, 1, 4);
    chk("rst_pattern_count", count8, 8'd1);

    // Saturation of the 2-bit counter over five overlapping matches.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sym(4'd1, 1, (i == 0) ? 1 : 3);
      sym(4'd2, 1, (i == 0) ? 2 : 4);
    end
    chk("sat_count8", count8, 8'd5);
    chk("sat_count2", count2, 2'd3);
    repeat (3) idle(4);
    sym(4'd1, 1, 3); sym(4'd2, 1, 4);
    chk("sat_hold2", count2, 2'd3);
    chk("sat_count8_6", count8, 8'd6);

    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
